// File: rtl/block_mean_buffer.sv
// block_mean_buffer: collects a block of TOTAL_SAMPLES samples, computes the
// block mean, then replays the stored samples behind a one-cycle start pulse
// so the downstream variance unit sees a stable mean with the same stream.
// Optional feature macro: BLOCK_MEAN_ROUND_EN (round-half-up mean with
// saturation); when undefined the mean is a truncating shift.
//
// Handshake: a sample transfers on a rising edge where valid_in && in_ready
// and rst is low. valid_in while in_ready is low drops the sample and sets the
// sticky drop_err. The output side has no backpressure: valid_out marks one
// sample per cycle that the consumer must take.
module block_mean_buffer #(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_SAMPLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    valid_in,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic                    start_data_out,
  output logic [2*DATA_WIDTH-1:0] mean_out,
  output logic                    mean_ready,
  output logic                    drop_err,
  output logic [1:0]              dbg_state
);

  localparam int PTR_W = $clog2(TOTAL_SAMPLES);
  localparam int SUM_W = DATA_WIDTH + PTR_W;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(TOTAL_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_MEAN    = 2'd1,
    ST_START   = 2'd2,
    ST_REPLAY  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [DATA_WIDTH-1:0] r_buf [TOTAL_SAMPLES];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [SUM_W-1:0]      r_sum;
  logic [DATA_WIDTH-1:0] r_data_hold;
  logic [2*DATA_WIDTH-1:0] r_mean;
  logic                  r_mean_ready;
  logic                  r_drop_err;

  logic                  w_in_ready;
  logic                  w_valid_out;
  logic                  w_start;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_mean_val;

  // Reset wins over an incoming sample.
  assign w_accept = valid_in && w_in_ready && !rst;

`ifdef BLOCK_MEAN_ROUND_EN
  // Rounding adder one bit wider than the accumulator; quotient keeps one
  // extra bit so a carry past DATA_WIDTH can be saturated.
  logic [DATA_WIDTH:0] w_round_q;
  assign w_round_q  = (DATA_WIDTH+1)'(({1'b0, r_sum} + (SUM_W+1)'(TOTAL_SAMPLES/2)) >> PTR_W);
  assign w_mean_val = w_round_q[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : w_round_q[DATA_WIDTH-1:0];
`else
  assign w_mean_val = DATA_WIDTH'(r_sum >> PTR_W);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_COLLECT;
    else     r_state <= w_next_state;
  end

  // Next-state and per-state control outputs.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_valid_out  = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        w_in_ready = 1'b1;
        if (valid_in && (r_wr_ptr == LAST_IDX)) w_next_state = ST_MEAN;
      end
      ST_MEAN: begin
        w_next_state = ST_START;
      end
      ST_START: begin
        w_start      = 1'b1;
        w_next_state = ST_REPLAY;
      end
      ST_REPLAY: begin
        w_valid_out = 1'b1;
        if (r_rd_ptr == LAST_IDX) w_next_state = ST_COLLECT;
      end
      default: w_next_state = ST_COLLECT;
    endcase
  end

  // Sample storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_wr_ptr] <= data_in;
  end

  // Pointers, accumulator, mean, held output sample and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_sum        <= '0;
      r_data_hold  <= '0;
      r_mean       <= '0;
      r_mean_ready <= 1'b0;
      r_drop_err   <= 1'b0;
    end else begin
      r_mean_ready <= 1'b0;
      if (valid_in && !w_in_ready) r_drop_err <= 1'b1;
      case (r_state)
        ST_COLLECT: begin
          if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_sum    <= r_sum + SUM_W'(data_in);
          end
        end
        ST_MEAN: begin
          r_mean       <= {{DATA_WIDTH{1'b0}}, w_mean_val};
          r_mean_ready <= 1'b1;
        end
        ST_START: begin
          r_sum    <= '0;
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
        end
        ST_REPLAY: begin
          r_data_hold <= r_buf[r_rd_ptr];
          r_rd_ptr    <= r_rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready       = w_in_ready;
  assign valid_out      = w_valid_out;
  assign start_data_out = w_start;
  assign data_out       = (r_state == ST_REPLAY) ? r_buf[r_rd_ptr] : r_data_hold;
  assign mean_out       = r_mean;
  assign mean_ready     = r_mean_ready;
  assign drop_err       = r_drop_err;
  assign dbg_state      = r_state;

endmodule
